// File: rtl/clk_switch_ctrl.sv
// ----------------------------------------------------------------------------
// clk_switch_ctrl
//
// Sequencing controller for a glitch-free two-clock mux. It collects switch
// requests for clkA / clkB and arbitrates between them round-robin. It drives
// the mux select line, then keeps busy high for a fixed settle window while
// the mux handshake completes. A hold-off window follows each completed
// switch. A switch onto a clock whose monitor reports it dead is refused.
// All logic runs on the free-running control clock.
//
// Ports:
//   clk      in   control clock (independent of clkA/clkB)
//   rst      in   synchronous active-high reset
//   req_a    in   pulse: request switch to clkA
//   req_b    in   pulse: request switch to clkB
//   alive_a  in   clkA monitor status (already synchronised to clk)
//   alive_b  in   clkB monitor status (already synchronised to clk)
//   lock     in   1 = no new grants (in-flight switch still completes)
//   select   out  mux select: 1 = clkA, 0 = clkB
//   busy     out  switch in progress (settle window)
//   done     out  one-cycle pulse: request completed
//   err      out  one-cycle pulse: request rejected, target clock dead
// ----------------------------------------------------------------------------
module clk_switch_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned MIN_HOLD      = 8,
    parameter bit          RESET_SEL     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic alive_a,
    input  logic alive_b,
    input  logic lock,
    output logic select,
    output logic busy,
    output logic done,
    output logic err
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST   = 8'((MIN_HOLD > 0) ? (MIN_HOLD - 1) : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic       pend_a, pend_a_n;
    logic       pend_b, pend_b_n;
    logic       last_a, last_a_n;   // 1 = last grant went to A, 0 = B
    logic       select_n, busy_n, done_n, err_n;
    logic       tgt_a, tgt_alive, clr_a, clr_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 8'd0;
            pend_a <= 1'b0;
            pend_b <= 1'b0;
            last_a <= 1'b0;
            select <= RESET_SEL;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            pend_a <= pend_a_n;
            pend_b <= pend_b_n;
            last_a <= last_a_n;
            select <= select_n;
            busy   <= busy_n;
            done   <= done_n;
            err    <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        select_n  = select;
        busy_n    = busy;
        done_n    = 1'b0;
        err_n     = 1'b0;
        last_a_n  = last_a;
        clr_a     = 1'b0;
        clr_b     = 1'b0;
        tgt_a     = 1'b0;
        tgt_alive = 1'b0;

        case (state)
            IDLE: begin
                if (!lock && (pend_a || pend_b)) begin
                    // Both pending: serve the source opposite the last grant.
                    if (pend_a && pend_b) tgt_a = !last_a;
                    else                  tgt_a = pend_a;
                    tgt_alive = tgt_a ? alive_a : alive_b;
                    clr_a     = tgt_a;
                    clr_b     = !tgt_a;
                    last_a_n  = tgt_a;
                    if (tgt_a == select) begin
                        // Already on the requested clock: acknowledge only.
                        done_n = 1'b1;
                    end else if (!tgt_alive) begin
                        err_n = 1'b1;
                    end else begin
                        select_n = tgt_a;
                        busy_n   = 1'b1;
                        cnt_n    = 8'd0;
                        state_n  = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    cnt_n   = 8'd0;
                    state_n = (MIN_HOLD == 0) ? IDLE : HOLD;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    cnt_n   = 8'd0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // A new request on the same edge as its clear keeps the flag set.
        pend_a_n = (pend_a && !clr_a) || req_a;
        pend_b_n = (pend_b && !clr_b) || req_b;
    end

endmodule

// File: doc/clk_switch_ctrl.md
# clk_switch_ctrl

Sequencing controller for the glitch-free two-clock mux. It accepts switch requests for clkA or clkB from two requesters and arbitrates between them. It drives the mux `select` line, then holds off further changes until the mux handshake has settled. It also refuses to switch onto a clock that the clock monitors report as dead. It runs on a single free-running control clock, separate from the two switched clocks.

## Interface
Parameters:
- SETTLE_CYCLES, 16 — control-clock cycles `busy` stays high after `select` changes (must cover 2 edges of the slower switched clock plus margin); range 1..255
- MIN_HOLD, 8 — cycles after a completed switch during which no new switch is granted; 0 disables
- RESET_SEL, 1 — `select` value after reset (1 = clkA, 0 = clkB)

Ports:
- clk  in  1  control clock, free-running, independent of clkA/clkB
- rst  in  1  reset; one clock; reset is synchronous and active-high
- req_a  in  1  single-cycle pulse: request switch to clkA
- req_b  in  1  single-cycle pulse: request switch to clkB
- alive_a  in  1  clkA monitor status, 1 = clkA toggling (already synchronised to clk)
- alive_b  in  1  clkB monitor status, same as alive_a
- lock  in  1  1 = freeze; no new grant while high
- select  out  1  to mux: 1 = clkA, 0 = clkB
- busy  out  1  switch in progress (SETTLE state)
- done  out  1  one-cycle pulse: request completed
- err  out  1  one-cycle pulse: request rejected, target clock dead

## Operation
- Reset values: select=RESET_SEL, busy=0, done=0, err=0, pend_a=pend_b=0, state=IDLE, counters=0, last_grant=B.
- Request capture: req_x=1 sets pend_x at the next edge, regardless of state. A pending flag absorbs repeat pulses, so a single service covers them.
- FSM states:
  - IDLE: if lock=0 and any pend is set, grant one request.
  - SETTLE: count SETTLE_CYCLES.
  - HOLD: count MIN_HOLD.
- Arbitration: if only one pend is set, grant it. If both are set, round-robin: grant the source opposite last_grant. last_grant updates on every grant.
- Grant actions, all taking effect at the grant edge; the granted pend is cleared at the same edge:
  - target == current select: done pulse, stay in IDLE, no settle, no hold.
  - target alive=0: err pulse, select unchanged, stay in IDLE.
  - otherwise: select <= target, busy <= 1, counter <= 0, go to SETTLE.
- SETTLE: counter increments each cycle. When counter == SETTLE_CYCLES-1: busy <= 0, done <= 1, go to HOLD (or IDLE if MIN_HOLD=0).
- HOLD: after MIN_HOLD cycles, go to IDLE. Requests arriving in SETTLE/HOLD stay pending.
- select changes only on a grant edge. It never changes while busy=1 or in HOLD.
- lock=1 blocks grants only. An in-flight SETTLE/HOLD completes normally, and pending flags are retained.
- The alive_x value used at grant time is sampled at the grant edge. A clock that dies during SETTLE does not abort the switch.
- rst=1 in any state: all registers take reset values at that edge. Pending requests are discarded, and select returns to RESET_SEL even mid-SETTLE.

## Timing
- req pulse at edge t → pend at t → grant at edge t+1 (if IDLE and unlocked). For a real switch, select/busy change at t+1.
- busy is high for exactly SETTLE_CYCLES cycles. done=1 during the cycle after the last busy cycle, and busy=0 at the same edge.
- Next grant edge ≥ done edge + MIN_HOLD.
- Same-source request and dead-target request: done or err at grant edge t+1, a one-cycle response.
- done and err never assert together. At most one grant per cycle.
- req_x arriving on the same edge its pend is cleared by a grant leaves pend_x set: set wins over clear.

## Test plan
1. Reset then idle: with RESET_SEL=1, after rst, select=1, busy=0; no req → outputs stay constant for 100 cycles.
2. Basic switch: alive_b=1, req_b at edge t → select=0 and busy=1 at t+1; busy low and done=1 at t+17 (SETTLE_CYCLES=16); next grant is not earlier than t+25.
3. Simultaneous req_a and req_b from select=0, last_grant=B: A is granted first (switch, select=1). After HOLD, B is granted (select=0). Exactly two done pulses.
4. Dead target: alive_b=0, req_b → err pulse at t+1, select stays 1, no busy. Same-source req_a → done at t+1, no busy.
5. Lock: lock=1, req_b → no grant for 50 cycles, pend held. Release lock → grant on the next edge.
6. Reset mid-SETTLE: rst at cycle 5 of SETTLE with a pending req_a → select=RESET_SEL, busy=0, no done/err afterwards, pending discarded.
